// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared constants, ALU function codes and helpers for the exec pipe
package exec_pkg;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;

  localparam logic [2:0] ALU_XOR  = 3'b000;
  localparam logic [2:0] ALU_XNOR = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_AND  = 3'b110;
  localparam logic [2:0] ALU_ZERO = 3'b111;

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/mips_exec_pipe_if.sv
// rtl/mips_exec_pipe_if.sv - decoder-to-exec signal bundle with decoder and pipe views
interface mips_exec_pipe_if;
  import exec_pkg::*;

  logic [DATA_W-1:0] ibus;
  logic [NREGS-1:0]  Aselect;
  logic [NREGS-1:0]  Bselect;
  logic [NREGS-1:0]  Dselect;
  logic              Imm;
  logic [2:0]        S;
  logic              Cin;
  logic [DATA_W-1:0] abus;
  logic [DATA_W-1:0] bbus;
  logic [DATA_W-1:0] dbus;
  logic              cout;
  logic              ovf;

  modport master (
    output ibus, Aselect, Bselect, Dselect, Imm, S, Cin,
    input  abus, bbus, dbus, cout, ovf
  );

  modport slave (
    input  ibus, Aselect, Bselect, Dselect, Imm, S, Cin,
    output abus, bbus, dbus, cout, ovf
  );
endinterface

// File: rtl/alu32.sv
// rtl/alu32.sv - combinational 32-bit ALU; flags only carry meaning for ADD and SUB
module alu32
  import exec_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        S,
  input  logic              Cin,
  output logic [DATA_W-1:0] result,
  output logic              cout,
  output logic              ovf
);
  logic [DATA_W-1:0] opb_eff;
  logic [DATA_W:0]   sum;

  // One adder serves both ADD and SUB; subtraction relies on Cin = 1 from the decoder
  assign opb_eff = (S == ALU_SUB) ? ~b : b;
  assign sum     = {1'b0, a} + {1'b0, opb_eff} + {{DATA_W{1'b0}}, Cin};

  always_comb begin
    result = '0;
    cout   = 1'b0;
    ovf    = 1'b0;
    case (S)
      ALU_XOR:  result = a ^ b;
      ALU_XNOR: result = ~(a ^ b);
      ALU_ADD, ALU_SUB: begin
        result = sum[DATA_W-1:0];
        cout   = sum[DATA_W];
        ovf    = (a[DATA_W-1] == opb_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_OR:   result = a | b;
      ALU_NOR:  result = ~(a | b);
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/mips_exec_pipe.sv
// rtl/mips_exec_pipe.sv - register file, EX stage and write-back with EX-to-ID forwarding
module mips_exec_pipe
  import exec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  mips_exec_pipe_if.slave  bus
);
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] regs [1:NREGS-1];
  logic [DATA_W-1:0] a_q, b_q, imm_q;
  logic [DATA_W-1:0] rf_a, rf_b, op_b, ex_result;
  logic [DATA_W-1:0] dbus_q;
  logic              cout_q, ovf_q, alu_cout, alu_ovf;
  logic [NREGS-1:0]  fwd_a, fwd_b;
  logic              ir_unused;

  // Upper instruction bits are decoded upstream; only the immediate is consumed here
  assign ir_unused = ^ir[DATA_W-1:16];

  always_comb begin
    rf_a = '0;
    rf_b = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (bus.Aselect[i]) rf_a = rf_a | regs[i];
      if (bus.Bselect[i]) rf_b = rf_b | regs[i];
    end
  end

  // r0 is masked out so a write aimed at r0 never leaks into a dependent read
  assign fwd_a    = bus.Aselect & bus.Dselect & ~32'h1;
  assign fwd_b    = bus.Bselect & bus.Dselect & ~32'h1;
  assign bus.abus = (|fwd_a) ? ex_result : rf_a;
  assign bus.bbus = (|fwd_b) ? ex_result : rf_b;

  assign op_b = bus.Imm ? imm_q : b_q;

  alu32 u_alu (
    .a      (a_q),
    .b      (op_b),
    .S      (bus.S),
    .Cin    (bus.Cin),
    .result (ex_result),
    .cout   (alu_cout),
    .ovf    (alu_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      imm_q  <= '0;
      dbus_q <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    end else begin
      ir     <= bus.ibus;
      a_q    <= bus.abus;
      b_q    <= bus.bbus;
      imm_q  <= sext16(ir[15:0]);
      dbus_q <= ex_result;
      cout_q <= alu_cout;
      ovf_q  <= alu_ovf;
      for (int i = 1; i < NREGS; i++) begin
        if (bus.Dselect[i]) regs[i] <= ex_result;
      end
    end
  end

  assign bus.dbus = dbus_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule
